fetch_unit: RTL and testbench

- Instruction-fetch front end; sits directly upstream of the decode stage and feeds it {pc, inst} pairs over a valid/ready handshake.
- Owns the PC register and issues in-order requests to instruction memory.
- Buffers responses in a small in-order queue.
- Accepts branch/jump redirects from later stages, flushing queued and in-flight fetches.

---
 rtl/fetch_unit.sv | 216 +++++++++++++++++++++
 tb/tb_fetch_unit.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
//
// Instruction-fetch front end. Owns the program counter, issues in-order
// word-aligned requests to instruction memory, buffers the returning
// instruction words in a small in-order queue and hands {pc, inst} pairs to
// the decode stage over a valid/ready handshake. A redirect from a later
// stage flushes everything buffered and in flight and restarts fetch at the
// new target.
//
// Parameters
//   XLEN      data/address width
//   RESET_PC  PC loaded on reset
//   QDEPTH    queue slots (power of two, >= 2); bounds requests in flight
//             plus buffered instructions
//
// Ports
//   clock, reset          rising-edge clock, synchronous active-high reset
//   io_imem_req_*         request channel to instruction memory (valid/ready)
//   io_imem_resp_*        in-order response channel, no backpressure
//   io_redirect_*         flush and restart fetch at io_redirect_pc
//   io_out_*              {pc, inst} towards decode (valid/ready)
//
// Optional build macro
//   FETCH_PERF_EN  adds io_perf_fetched (output handshakes) and
//                  io_perf_bubbles (cycles where decode was ready but no
//                  instruction was offered). Both are 32-bit wrapping
//                  counters cleared by reset.
// ---------------------------------------------------------------------------
module fetch_unit #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              QDEPTH   = 2
) (
  input  logic            clock,
  input  logic            reset,
  output logic            io_imem_req_valid,
  input  logic            io_imem_req_ready,
  output logic [XLEN-1:0] io_imem_req_addr,
  input  logic            io_imem_resp_valid,
  input  logic [XLEN-1:0] io_imem_resp_data,
  input  logic            io_redirect_valid,
  input  logic [XLEN-1:0] io_redirect_pc,
  output logic            io_out_valid,
  input  logic            io_out_ready,
  output logic [XLEN-1:0] io_out_pc,
  output logic [XLEN-1:0] io_out_inst
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]     io_perf_fetched,
  output logic [31:0]     io_perf_bubbles
`endif
);

  localparam int PW = $clog2(QDEPTH);
  localparam int CW = $clog2(QDEPTH + 1);

  localparam logic [PW-1:0]   PTR_ONE   = PW'(1);
  localparam logic [CW-1:0]   CNT_ONE   = CW'(1);
  localparam logic [CW:0]     SUM_ONE   = (CW + 1)'(1);
  localparam logic [CW:0]     DEPTH_SUM = (CW + 1)'(QDEPTH);
  localparam logic [XLEN-1:0] PC_STEP   = XLEN'(4);

  // Architectural fetch PC (next address to request)
  logic [XLEN-1:0] pc;

  // Queue storage: one entry per outstanding or buffered fetch
  logic [XLEN-1:0] slot_pc   [QDEPTH];
  logic [XLEN-1:0] slot_inst [QDEPTH];
  logic [QDEPTH-1:0] slot_filled;

  // head: oldest entry, alloc: next free slot, fill: next slot awaiting data
  logic [PW-1:0] head;
  logic [PW-1:0] alloc;
  logic [PW-1:0] fill;

  // occ: live entries, pending: live entries still waiting for imem,
  // drop_cnt: responses still owed by imem for flushed requests
  logic [CW-1:0] occ;
  logic [CW-1:0] pending;
  logic [CW-1:0] drop_cnt;
  logic [CW-1:0] occ_next;
  logic [CW-1:0] pending_next;
  logic [CW-1:0] drop_next;

  logic [CW:0] budget_used;
  logic [CW:0] flush_sum;

  logic accept;
  logic fire;
  logic resp_fill;
  logic resp_drop;

  // Every request the imem still owes us (live or flushed) occupies budget,
  // so a flushed stream cannot overrun the queue when its data trickles back.
  assign budget_used = {1'b0, occ} + {1'b0, drop_cnt};

  assign io_imem_req_valid = !reset && !io_redirect_valid && (budget_used < DEPTH_SUM);
  assign io_imem_req_addr  = pc;

  assign io_out_valid = !reset && !io_redirect_valid && slot_filled[head];
  assign io_out_pc    = slot_pc[head];
  assign io_out_inst  = slot_inst[head];

  assign accept = io_imem_req_valid && io_imem_req_ready;
  assign fire   = io_out_valid && io_out_ready;

  // Responses pay off flushed requests first because the imem answers in
  // order and flushed requests were always issued before live ones.
  assign resp_drop = io_imem_resp_valid && !io_redirect_valid && (drop_cnt != '0);
  assign resp_fill = io_imem_resp_valid && !io_redirect_valid && (drop_cnt == '0) && (pending != '0);

  // Bookkeeping counters. On a redirect all live unfilled entries become
  // owed drops; a response arriving in that same cycle belongs to the old
  // stream and pays one of them off immediately.
  always_comb begin
    occ_next     = occ;
    pending_next = pending;
    drop_next    = drop_cnt;
    flush_sum    = {1'b0, drop_cnt} + {1'b0, pending};
    if (io_redirect_valid) begin
      occ_next     = '0;
      pending_next = '0;
      if (io_imem_resp_valid && (flush_sum != '0)) begin
        flush_sum = flush_sum - SUM_ONE;
      end
      drop_next = flush_sum[CW-1:0];
    end else begin
      if (accept && !fire) begin
        occ_next = occ + CNT_ONE;
      end else if (!accept && fire) begin
        occ_next = occ - CNT_ONE;
      end
      if (accept && !resp_fill) begin
        pending_next = pending + CNT_ONE;
      end else if (!accept && resp_fill) begin
        pending_next = pending - CNT_ONE;
      end
      if (resp_drop) begin
        drop_next = drop_cnt - CNT_ONE;
      end
    end
  end

  // Counter registers
  always_ff @(posedge clock) begin
    if (reset) begin
      occ      <= '0;
      pending  <= '0;
      drop_cnt <= '0;
    end else begin
      occ      <= occ_next;
      pending  <= pending_next;
      drop_cnt <= drop_next;
    end
  end

  // PC, queue pointers and slot contents. Allocation, fill and release can
  // all happen in one cycle; they always touch different slots because an
  // allocation only happens into a free slot, a fill only into an allocated
  // unfilled slot and a release only from a filled head slot.
  always_ff @(posedge clock) begin
    if (reset) begin
      pc          <= RESET_PC;
      head        <= '0;
      alloc       <= '0;
      fill        <= '0;
      slot_filled <= '0;
      for (int i = 0; i < QDEPTH; i++) begin
        slot_pc[i]   <= '0;
        slot_inst[i] <= '0;
      end
    end else if (io_redirect_valid) begin
      pc          <= {io_redirect_pc[XLEN-1:2], 2'b00};
      head        <= '0;
      alloc       <= '0;
      fill        <= '0;
      slot_filled <= '0;
    end else begin
      if (accept) begin
        slot_pc[alloc]     <= pc;
        slot_filled[alloc] <= 1'b0;
        alloc              <= alloc + PTR_ONE;
        pc                 <= pc + PC_STEP;
      end
      if (resp_fill) begin
        slot_inst[fill]   <= io_imem_resp_data;
        slot_filled[fill] <= 1'b1;
        fill              <= fill + PTR_ONE;
      end
      if (fire) begin
        slot_filled[head] <= 1'b0;
        head              <= head + PTR_ONE;
      end
    end
  end

`ifdef FETCH_PERF_EN
  // Performance counters; io_out_valid is already forced low during reset,
  // and the reset branch clears them anyway.
  always_ff @(posedge clock) begin
    if (reset) begin
      io_perf_fetched <= '0;
      io_perf_bubbles <= '0;
    end else begin
      if (fire) begin
        io_perf_fetched <= io_perf_fetched + 32'd1;
      end
      if (io_out_ready && !io_out_valid) begin
        io_perf_bubbles <= io_perf_bubbles + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_unit
//
// Scoreboard bench for fetch_unit. The stimulus side drives the imem model,
// redirects and decode backpressure, and pushes each expected {pc, inst} into
// a queue when a request is issued. A separate monitor process decides from
// the reference model when decode should see an instruction, pops the
// queue on each expected handshake and compares against the DUT.
// The DUT runs with RESET_PC near the top of the address space so the PC
// wrap is exercised from the start.
// ---------------------------------------------------------------------------
module tb_fetch_unit;

  localparam int          XLEN     = 32;
  localparam int          QDEPTH   = 2;
  localparam logic [31:0] RESET_PC = 32'hFFFF_FFF8;
  localparam int          NEVER    = 32'h7FFF_FFFF;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        io_imem_req_valid;
  logic        io_imem_req_ready = 1'b0;
  logic [31:0] io_imem_req_addr;
  logic        io_imem_resp_valid = 1'b0;
  logic [31:0] io_imem_resp_data = '0;
  logic        io_redirect_valid = 1'b0;
  logic [31:0] io_redirect_pc = '0;
  logic        io_out_valid;
  logic        io_out_ready = 1'b0;
  logic [31:0] io_out_pc;
  logic [31:0] io_out_inst;
`ifdef FETCH_PERF_EN
  logic [31:0] io_perf_fetched;
  logic [31:0] io_perf_bubbles;
`endif

  fetch_unit #(
    .XLEN     (XLEN),
    .RESET_PC (RESET_PC),
    .QDEPTH   (QDEPTH)
  ) dut (
    .clock              (clock),
    .reset              (reset),
    .io_imem_req_valid  (io_imem_req_valid),
    .io_imem_req_ready  (io_imem_req_ready),
    .io_imem_req_addr   (io_imem_req_addr),
    .io_imem_resp_valid (io_imem_resp_valid),
    .io_imem_resp_data  (io_imem_resp_data),
    .io_redirect_valid  (io_redirect_valid),
    .io_redirect_pc     (io_redirect_pc),
    .io_out_valid       (io_out_valid),
    .io_out_ready       (io_out_ready),
    .io_out_pc          (io_out_pc),
    .io_out_inst        (io_out_inst)
`ifdef FETCH_PERF_EN
    ,
    .io_perf_fetched    (io_perf_fetched),
    .io_perf_bubbles    (io_perf_bubbles)
`endif
  );

  always #5 clock = ~clock;

  // Expected decode-side entry and imem in-flight request
  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    int          ready_cycle;
  } exp_t;

  typedef struct {
    int          tag;
    int          due;
    logic [31:0] data;
  } imem_t;

  exp_t        exp_q[$];
  imem_t       imem_q[$];
  int          stream = 0;
  int          cyc = 0;
  int          checks = 0;
  int          fails = 0;
  int          model_fetched = 0;
  int          model_bubbles = 0;
  logic [31:0] model_pc = RESET_PC;

  logic        acc_d;
  logic [31:0] addr_d;

  // Cycle index, stable between rising edges
  always @(posedge clock) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // One clock of stimulus. mode: 0 hold imem responses, 1 respond as soon as
  // due, 2 respond randomly when due. Reports whether a request was accepted
  // and the address the DUT presented.
  task automatic applyStimulus(input logic redir, input logic [31:0] rpc, input logic rdy,
                               input logic ordy, input int mode,
                               output logic accepted, output logic [31:0] addr_seen);
    logic  do_resp;
    logic  exp_rv;
    int    stale;
    bit    found;
    imem_t e;
    exp_t  n;
    @(negedge clock);
    reset             = 1'b0;
    io_redirect_valid = redir;
    io_redirect_pc    = rpc;
    io_imem_req_ready = rdy;
    io_out_ready      = ordy;
    do_resp = 1'b0;
    if (imem_q.size() > 0) begin
      if (imem_q[0].due <= cyc) begin
        if (mode == 1) do_resp = 1'b1;
        else if (mode == 2) do_resp = ($urandom_range(0, 3) != 0);
      end
    end
    io_imem_resp_valid = do_resp;
    if (do_resp) io_imem_resp_data = imem_q[0].data;
    else io_imem_resp_data = $urandom;
    #1;
    stale = 0;
    foreach (imem_q[i]) if (imem_q[i].tag != stream) stale++;
    exp_rv = !redir && ((exp_q.size() + stale) < QDEPTH);
    checkOutput("req_valid", {31'b0, io_imem_req_valid}, {31'b0, exp_rv});
    checkOutput("req_addr", io_imem_req_addr, model_pc);
    accepted  = exp_rv && rdy;
    addr_seen = io_imem_req_addr;
    if (do_resp) begin
      e = imem_q.pop_front();
      if (!redir && e.tag == stream) begin
        found = 1'b0;
        foreach (exp_q[i]) begin
          if (!found && exp_q[i].ready_cycle == NEVER) begin
            exp_q[i].ready_cycle = cyc + 1;
            found = 1'b1;
          end
        end
      end
    end
    if (redir) begin
      exp_q.delete();
      stream++;
      model_pc = {rpc[31:2], 2'b00};
    end else if (accepted) begin
      e.tag  = stream;
      e.due  = cyc + 1;
      e.data = $urandom;
      imem_q.push_back(e);
      n.pc          = model_pc;
      n.inst        = e.data;
      n.ready_cycle = NEVER;
      exp_q.push_back(n);
      model_pc = model_pc + 32'd4;
    end
    #2;
  endtask

  // Hold reset for n cycles, then check the clean post-reset state
  task automatic applyReset(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clock);
      reset              = 1'b1;
      io_redirect_valid  = 1'b0;
      io_imem_req_ready  = 1'($urandom_range(0, 1));
      io_out_ready       = 1'b0;
      io_imem_resp_valid = 1'b0;
      #1;
      checkOutput("rst_req_valid", {31'b0, io_imem_req_valid}, 32'd0);
      checkOutput("rst_out_valid", {31'b0, io_out_valid}, 32'd0);
      exp_q.delete();
      imem_q.delete();
      stream++;
      model_pc = RESET_PC;
      #2;
    end
    @(negedge clock);
    reset              = 1'b0;
    io_redirect_valid  = 1'b0;
    io_imem_req_ready  = 1'b0;
    io_out_ready       = 1'b0;
    io_imem_resp_valid = 1'b0;
    #1;
    checkOutput("post_rst_out_valid", {31'b0, io_out_valid}, 32'd0);
    checkOutput("post_rst_out_pc", io_out_pc, 32'd0);
    checkOutput("post_rst_out_inst", io_out_inst, 32'd0);
    checkOutput("post_rst_req_addr", io_imem_req_addr, RESET_PC);
    checkOutput("post_rst_req_valid", {31'b0, io_imem_req_valid}, 32'd1);
`ifdef FETCH_PERF_EN
    checkOutput("post_rst_perf_fetched", io_perf_fetched, 32'd0);
    checkOutput("post_rst_perf_bubbles", io_perf_bubbles, 32'd0);
`endif
    #2;
  endtask

  // Stop issuing, let everything outstanding drain through decode
  task automatic drain();
    int budget;
    budget = 0;
    while ((imem_q.size() != 0 || exp_q.size() != 0) && budget < 100) begin
      applyStimulus(1'b0, 32'd0, 1'b0, 1'b1, 1, acc_d, addr_d);
      budget++;
    end
    checks++;
    if (budget >= 100) begin
      fails++;
      $display("[TB] FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
    end
  endtask

  // Wait for decode to be offered an instruction and check its pc
  task automatic waitFirstOut(input string name, input logic [31:0] want);
    int budget;
    budget = 0;
    do begin
      applyStimulus(1'b0, 32'd0, 1'b1, 1'b0, 1, acc_d, addr_d);
      budget++;
    end while (!io_out_valid && budget < 20);
    if (!io_out_valid) begin
      checks++;
      fails++;
      $display("[TB] FAIL %s_timeout: got out_valid 0 expected 1", name);
    end else begin
      checkOutput(name, io_out_pc, want);
    end
  endtask

  // Monitor: model-driven output check, pops the scoreboard on each
  // expected handshake and tracks the performance counter model.
  initial begin : monitor
    logic exp_valid;
    exp_t n;
    forever begin
      @(negedge clock);
      #2;
      if (reset) begin
        model_fetched = 0;
        model_bubbles = 0;
        checkOutput("mon_rst_out_valid", {31'b0, io_out_valid}, 32'd0);
        checkOutput("mon_rst_req_valid", {31'b0, io_imem_req_valid}, 32'd0);
      end else begin
        exp_valid = 1'b0;
        if (exp_q.size() > 0) begin
          exp_valid = (exp_q[0].ready_cycle <= cyc) && !io_redirect_valid;
        end
        checkOutput("out_valid", {31'b0, io_out_valid}, {31'b0, exp_valid});
        if (io_out_ready && !exp_valid) model_bubbles++;
        if (exp_valid && io_out_ready) begin
          n = exp_q.pop_front();
          checkOutput("out_pc", io_out_pc, n.pc);
          checkOutput("out_inst", io_out_inst, n.inst);
          model_fetched++;
        end
      end
    end
  end

  initial begin : watchdog
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    int first_acc;
    int first_val;
    int acc_cnt;
    int budget;
    logic redir;
    applyReset(3);

    // Decode stalled: exactly QDEPTH requests, then fetch must stop
    first_acc = -1;
    first_val = -1;
    acc_cnt   = 0;
    for (int k = 0; k < 10; k++) begin
      applyStimulus(1'b0, 32'd0, 1'b1, 1'b0, 1, acc_d, addr_d);
      if (acc_d) begin
        acc_cnt++;
        if (first_acc < 0) first_acc = cyc;
        if (acc_cnt == 1) checkOutput("first_addr", addr_d, 32'hFFFF_FFF8);
        if (acc_cnt == 2) checkOutput("second_addr", addr_d, 32'hFFFF_FFFC);
      end
      if (io_out_valid && first_val < 0) first_val = cyc;
    end
    checkOutput("stalled_accepts", acc_cnt, QDEPTH);
    checkOutput("first_out_latency", first_val - first_acc, 32'd2);
    checkOutput("full_req_valid", {31'b0, io_imem_req_valid}, 32'd0);

    // Release decode: order preserved, then the PC wraps to zero
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b1, 1, acc_d, addr_d);
    checkOutput("order_first", io_out_pc, 32'hFFFF_FFF8);
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b1, 1, acc_d, addr_d);
    checkOutput("order_second", io_out_pc, 32'hFFFF_FFFC);
    budget = 0;
    do begin
      applyStimulus(1'b0, 32'd0, 1'b1, 1'b1, 1, acc_d, addr_d);
      budget++;
    end while (!acc_d && budget < 10);
    checkOutput("wrap_addr", addr_d, 32'h0000_0000);
    for (int k = 0; k < 12; k++) applyStimulus(1'b0, 32'd0, 1'b1, 1'b1, 1, acc_d, addr_d);
    drain();

    // Redirect with two requests in flight: both late responses are dropped
    applyStimulus(1'b0, 32'd0, 1'b1, 1'b0, 0, acc_d, addr_d);
    applyStimulus(1'b0, 32'd0, 1'b1, 1'b0, 0, acc_d, addr_d);
    applyStimulus(1'b1, 32'h0000_1003, 1'b0, 1'b1, 0, acc_d, addr_d);
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b1, 0, acc_d, addr_d);
    checkOutput("redirect_addr", addr_d, 32'h0000_1000);
    waitFirstOut("redirect_first_pc", 32'h0000_1000);
    drain();

    // Redirect colliding with a response and a ready head entry
    applyStimulus(1'b0, 32'd0, 1'b1, 1'b0, 0, acc_d, addr_d);
    applyStimulus(1'b0, 32'd0, 1'b1, 1'b0, 1, acc_d, addr_d);
    applyStimulus(1'b1, 32'h0000_2000, 1'b0, 1'b1, 1, acc_d, addr_d);
    checkOutput("redirect_cycle_out_valid", {31'b0, io_out_valid}, 32'd0);
    waitFirstOut("collide_first_pc", 32'h0000_2000);
    drain();

    // Randomized traffic
    for (int k = 0; k < 3000; k++) begin
      redir = ($urandom_range(0, 15) == 0);
      applyStimulus(redir, $urandom, 1'($urandom_range(0, 3) != 0),
                    1'($urandom_range(0, 3) != 0), 2, acc_d, addr_d);
    end
    drain();

    // Fill the queue, then reset mid-stream
    budget = 0;
    do begin
      applyStimulus(1'b0, 32'd0, 1'b1, 1'b0, 1, acc_d, addr_d);
      budget++;
    end while (io_imem_req_valid && budget < 30);
    checkOutput("full_before_reset", {31'b0, io_imem_req_valid}, 32'd0);
    applyReset(1);

    for (int k = 0; k < 500; k++) begin
      redir = ($urandom_range(0, 15) == 0);
      applyStimulus(redir, $urandom, 1'($urandom_range(0, 3) != 0),
                    1'($urandom_range(0, 3) != 0), 2, acc_d, addr_d);
    end
    drain();
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 1, acc_d, addr_d);
`ifdef FETCH_PERF_EN
    checkOutput("perf_fetched", io_perf_fetched, model_fetched);
    checkOutput("perf_bubbles", io_perf_bubbles, model_bubbles);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
